wb_cmd_sequencer: RTL

//  Converts host endpoint command words into Wishbone strobe/command transactions for the SPI master.
//  Per-channel interrupts run an autonomous read sequence, so ADC data moves to the FIFO without host action.

---
 rtl/wb_cmd_sequencer_pkg.sv | 16 +
 rtl/wb_cmd_sequencer_if.sv | 25 ++
 rtl/wb_cmd_sequencer_rr_arbiter.sv | 40 ++++
 rtl/wb_cmd_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/wb_cmd_sequencer_pkg.sv
// Shared types for the Wishbone command sequencer.
//   CMD_W        : width of a command word to the SPI master
//   state_t      : sequencer FSM states
//   src_t        : origin of the command currently being issued
//   fmt_host_cmd : widens a 32-bit host word into the 34-bit command format
package wb_cmd_pkg;
  localparam int CMD_W = 34;

  typedef enum logic [1:0] {IDLE, SETUP, STB, GAP} state_t;
  typedef enum logic {HOST, IRQ} src_t;

  // Top two host bits are the opcode; two zero bits are inserted below them.
  function automatic logic [CMD_W-1:0] fmt_host_cmd(input logic [31:0] d);
    return {d[31:30], 2'b00, d[29:0]};
  endfunction
endpackage

// File: rtl/wb_cmd_sequencer_if.sv
// Host/interrupt/Wishbone signal bundle for wb_cmd_sequencer.
//   ep_dataout, trigger : host command word and single-cycle request
//   int_i               : per-channel level interrupts
//   o_stb, cmd_word     : Wishbone strobe and command to the SPI master
//   o_ch                : channel of the current interrupt sequence
//   o_busy, o_ovf       : sequencer active / sticky host overflow
// slave = the sequencer, master = whoever drives host and interrupt lines.
interface wb_cmd_sequencer_if #(parameter int NCH = 2);
  import wb_cmd_pkg::*;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [31:0]      ep_dataout;
  logic             trigger;
  logic [NCH-1:0]   int_i;
  logic             o_stb;
  logic [CMD_W-1:0] cmd_word;
  logic [CHW-1:0]   o_ch;
  logic             o_busy;
  logic             o_ovf;

  modport slave  (input  ep_dataout, trigger, int_i,
                  output o_stb, cmd_word, o_ch, o_busy, o_ovf);
  modport master (output ep_dataout, trigger, int_i,
                  input  o_stb, cmd_word, o_ch, o_busy, o_ovf);
endinterface

// File: rtl/wb_cmd_sequencer_rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst  : clock, async active-high reset
//   i_req     : N request lines
//   i_accept  : the current grant is taken; advance the pointer
//   o_gnt     : one-hot grant, searched from last granted + 1
//   o_gnt_idx : binary index of o_gnt
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_gnt_idx
);
  // Reset to the last channel so the first search starts at channel 0.
  logic [PW-1:0] r_last;
  logic [PW-1:0] w_c;

  // Walk offsets from far to near so the nearest requester after r_last wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = r_last;
    w_c       = '0;
    for (int k = N; k >= 1; k--) begin
      w_c = PW'((int'(r_last) + k) % N);
      if (i_req[w_c]) begin
        o_gnt     = N'(1) << w_c;
        o_gnt_idx = w_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_last <= PW'(N - 1);
    else if (i_accept && |i_req) r_last <= o_gnt_idx;
  end
endmodule

// File: rtl/wb_cmd_sequencer.sv
// Turns host command words and per-channel interrupts into timed Wishbone
// strobe/command transactions for the SPI master.
//   clk, rst : clock, async active-high reset
//   bus      : wb_cmd_sequencer_if slave (host word/trigger, int_i in;
//              o_stb, cmd_word, o_ch, o_busy, o_ovf out)
// A host command issues one SETUP/STB/GAP frame; an interrupt edge issues
// RD_WORDS frames (READ_CMD then zero words) without host involvement.
module wb_cmd_sequencer import wb_cmd_pkg::*; #(
  parameter int               NCH       = 2,
  parameter int               SETUP_CYC = 1,
  parameter int               STB_CYC   = 2,
  parameter int               GAP_CYC   = 1,
  parameter int               RD_WORDS  = 2,
  parameter logic [CMD_W-1:0] READ_CMD  = 34'h200000001
) (
  input logic               clk,
  input logic               rst,
  wb_cmd_sequencer_if.slave bus
);
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MAXC  = (SETUP_CYC > STB_CYC) ?
                         ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                         ((STB_CYC > GAP_CYC) ? STB_CYC : GAP_CYC);
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int IDXW  = $clog2(RD_WORDS + 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STB   = CNT_W'(STB_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CYC - 1);
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(RD_WORDS - 1);

  state_t           r_state, w_state_nxt;
  src_t             r_src;
  logic [CNT_W-1:0] r_cnt;
  logic [IDXW-1:0]  r_idx;
  logic             r_hp, r_ovf;
  logic [CMD_W-1:0] r_hw, r_cmd;
  logic [NCH-1:0]   r_ip, r_int_d;
  logic [CHW-1:0]   r_ch;

  logic [NCH-1:0]   w_int_edge, w_gnt;
  logic [CHW-1:0]   w_gnt_idx;
  logic             w_take_host, w_take_irq, w_cnt_done, w_more;

  // r_int_d resets to 0, so a line already high out of reset is an edge.
  assign w_int_edge  = bus.int_i & ~r_int_d;
  assign w_take_host = (r_state == IDLE) && r_hp;
  assign w_take_irq  = (r_state == IDLE) && !r_hp && (|r_ip);
  assign w_cnt_done  = (r_cnt == '0);
  assign w_more      = (r_src == IRQ) && (r_idx < IDX_LAST);

  rr_arbiter #(.N(NCH), .PW(CHW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (r_ip),
    .i_accept  (w_take_irq),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (r_hp || (|r_ip)) w_state_nxt = SETUP;
      SETUP:   if (w_cnt_done)      w_state_nxt = STB;
      STB:     if (w_cnt_done)      w_state_nxt = GAP;
      GAP:     if (w_cnt_done)      w_state_nxt = w_more ? SETUP : IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs, decoded from the state register only
  always_comb begin
    bus.o_stb    = (r_state == STB);
    bus.o_busy   = (r_state != IDLE);
    bus.cmd_word = r_cmd;
    bus.o_ch     = r_ch;
    bus.o_ovf    = r_ovf;
  end

  // One shared down-counter, reloaded on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (w_state_nxt != r_state) begin
      unique case (w_state_nxt)
        SETUP:   r_cnt <= LD_SETUP;
        STB:     r_cnt <= LD_STB;
        GAP:     r_cnt <= LD_GAP;
        default: r_cnt <= '0;
      endcase
    end else if (!w_cnt_done) r_cnt <= r_cnt - CNT_W'(1);
  end

  // Command load, request capture and pending bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd   <= '0;
      r_src   <= HOST;
      r_ch    <= '0;
      r_idx   <= '0;
      r_hp    <= 1'b0;
      r_hw    <= '0;
      r_ovf   <= 1'b0;
      r_ip    <= '0;
      r_int_d <= '0;
    end else begin
      if (w_take_host) begin
        r_cmd <= r_hw;
        r_src <= HOST;
        r_hp  <= 1'b0;
      end else if (w_take_irq) begin
        r_cmd <= READ_CMD;
        r_src <= IRQ;
        r_ch  <= w_gnt_idx;
        r_idx <= '0;
      end else if ((r_state == GAP) && w_cnt_done && w_more) begin
        r_cmd <= '0;
        r_idx <= r_idx + IDXW'(1);
      end
      // A second trigger while one is still queued is dropped, not merged.
      if (bus.trigger) begin
        if (r_hp) r_ovf <= 1'b1;
        else begin
          r_hp <= 1'b1;
          r_hw <= fmt_host_cmd(bus.ep_dataout);
        end
      end
      // A new edge on the channel being granted re-pends it.
      r_ip    <= (r_ip & ~(w_take_irq ? w_gnt : '0)) | w_int_edge;
      r_int_d <= bus.int_i;
    end
  end
endmodule
